// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

    // Widest row or column bus the scanner supports.
    localparam int MAX_LINES = 16;

    // Scanner control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        CONFIRM = 2'd2,
        HELD    = 2'd3
    } scan_state_t;

    // Smallest width w such that 2**w >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int w = 31; w >= 0; w--) begin
            if ((64'd1 << w) >= 64'(value)) begin
                width = w;
            end
        end
        return width;
    endfunction

    // Width of a key code covering every row/column crossing.
    function automatic int code_width(input int n_rows, input int n_cols);
        return clog2(n_rows * n_cols);
    endfunction

    // Index of the lowest set bit; zero when no bit is set.
    function automatic logic [3:0] lowest_set(input logic [MAX_LINES-1:0] pattern);
        logic [3:0] index;
        index = '0;
        for (int i = MAX_LINES - 1; i >= 0; i--) begin
            if (pattern[i]) begin
                index = 4'(i);
            end
        end
        return index;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Column dwell counter: emits a sample strobe once every SCAN_DIV cycles.
module scan_tick_gen
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    output logic strobe
);

    localparam int DWELL_W = clog2(SCAN_DIV);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

    logic [DWELL_W-1:0] dwell;

    // Count the dwell of the driven column, wrapping after the sampling cycle.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            dwell <= '0;
        end else if (dwell == DWELL_LAST) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    assign strobe = !clear && (dwell == DWELL_LAST);

endmodule

// File: rtl/keypad_scan_deb.sv
// Matrix keypad scanner with press/release debounce and a one-entry key register.
module keypad_scan_deb
    import keypad_pkg::*;
#(
    parameter int N_COLS   = 4,
    parameter int N_ROWS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic                                    en,
    input  logic [N_ROWS-1:0]                       row_in,
    output logic [N_COLS-1:0]                       col_drv,
    output logic [code_width(N_ROWS, N_COLS)-1:0]   key_code,
    output logic                                    key_valid,
    input  logic                                    key_ready,
    output logic                                    key_held,
    output logic                                    overflow
);

    localparam int CODE_W = code_width(N_ROWS, N_COLS);
    localparam int COL_W  = clog2(N_COLS);
    localparam int CNT_W  = clog2(DEBOUNCE + 1);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(N_COLS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [N_COLS-1:0] COL_ONE  = N_COLS'(1);

    scan_state_t        state;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   col_next;
    logic [N_ROWS-1:0]  pattern;
    logic [CNT_W-1:0]   deb_cnt;
    logic [CODE_W-1:0]  emit_code;
    logic               sample_strobe;
    logic               scan_clear;
    logic               row_zero;
    logic               row_match;
    logic               confirm_now;

    // The dwell counter only runs while a column is actually being scanned.
    assign scan_clear = (state == IDLE) || !en;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (scan_clear),
        .strobe (sample_strobe)
    );

    // Next column with explicit wrap, sample classification and the code to emit.
    always_comb begin
        col_next  = (col == COL_LAST) ? '0 : col + 1'b1;
        row_zero  = (row_in == '0);
        row_match = (row_in == pattern);
        emit_code = CODE_W'(int'(lowest_set(MAX_LINES'(row_in))) * N_COLS + int'(col));
        confirm_now = 1'b0;
        if (sample_strobe && !row_zero) begin
            if (state == SCAN && DEBOUNCE == 1) begin
                confirm_now = 1'b1;
            end else if (state == CONFIRM && row_match && deb_cnt == CNT_LAST) begin
                confirm_now = 1'b1;
            end
        end
    end

    // Scan FSM, debounce counter and the registered key/handshake outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            col       <= '0;
            pattern   <= '0;
            deb_cnt   <= '0;
            col_drv   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end

            if (!en) begin
                state    <= IDLE;
                col      <= '0;
                pattern  <= '0;
                deb_cnt  <= '0;
                col_drv  <= '0;
                key_held <= 1'b0;
            end else if (confirm_now) begin
                if (!key_valid || key_ready) begin
                    key_code  <= emit_code;
                    key_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
                key_held <= 1'b1;
                pattern  <= row_in;
                deb_cnt  <= '0;
                state    <= HELD;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= SCAN;
                        col     <= '0;
                        col_drv <= COL_ONE;
                        deb_cnt <= '0;
                    end
                    SCAN: begin
                        if (sample_strobe) begin
                            if (row_zero) begin
                                col     <= col_next;
                                col_drv <= COL_ONE << col_next;
                            end else begin
                                pattern <= row_in;
                                deb_cnt <= CNT_ONE;
                                state   <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (sample_strobe) begin
                            if (row_zero) begin
                                state   <= SCAN;
                                deb_cnt <= '0;
                                col     <= col_next;
                                col_drv <= COL_ONE << col_next;
                            end else if (row_match) begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end else begin
                                pattern <= row_in;
                                deb_cnt <= CNT_ONE;
                            end
                        end
                    end
                    HELD: begin
                        if (sample_strobe) begin
                            if (!row_zero) begin
                                deb_cnt <= '0;
                            end else if (deb_cnt == CNT_LAST) begin
                                key_held <= 1'b0;
                                deb_cnt  <= '0;
                                state    <= SCAN;
                                col      <= col_next;
                                col_drv  <= COL_ONE << col_next;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_deb.sv
// Directed self-checking bench for keypad_scan_deb (4x4 and 3x5 configurations).
module tb_keypad_scan_deb;

    logic        CLK;
    logic        RESET;
    logic        en;

    // 4x4 instance, SCAN_DIV=4, DEBOUNCE=3
    logic [3:0]  row_in;
    logic [3:0]  col_drv;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_held;
    logic        overflow;
    logic [15:0] keys;

    // 3-column x 5-row instance, SCAN_DIV=4, DEBOUNCE=1
    logic [4:0]  row_in2;
    logic [2:0]  col_drv2;
    logic [3:0]  key_code2;
    logic        key_valid2;
    logic        key_ready2;
    logic        key_held2;
    logic        overflow2;
    logic [14:0] keys2;

    int checks;
    int failures;
    int cyc;

    keypad_scan_deb #(
        .N_COLS   (4),
        .N_ROWS   (4),
        .SCAN_DIV (4),
        .DEBOUNCE (3)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .en        (en),
        .row_in    (row_in),
        .col_drv   (col_drv),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    keypad_scan_deb #(
        .N_COLS   (3),
        .N_ROWS   (5),
        .SCAN_DIV (4),
        .DEBOUNCE (1)
    ) dut2 (
        .CLK       (CLK),
        .RESET     (RESET),
        .en        (en),
        .row_in    (row_in2),
        .col_drv   (col_drv2),
        .key_code  (key_code2),
        .key_valid (key_valid2),
        .key_ready (key_ready2),
        .key_held  (key_held2),
        .overflow  (overflow2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Keypad model: a pressed key at (r,c) pulls row r high while column c is driven.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && col_drv[c]) row_in[r] = 1'b1;
            end
        end
    end

    always_comb begin
        row_in2 = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (keys2[r*3+c] && col_drv2[c]) row_in2[r] = 1'b1;
            end
        end
    end

    // Reset both instances; returns mid-cycle 0 (first cycle after release).
    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        cyc = 0;
    endtask

    // Advance to the middle (negedge) of the given cycle.
    task automatic goto_cycle(input int target);
        while (cyc < target) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic test_reset();
        en = 1'b1; key_ready = 1'b0; key_ready2 = 1'b0; keys = '0; keys2 = '0;
        do_reset();
        checks++;
        if (col_drv !== 4'b0000) begin failures++; $display("[TB] FAIL reset_col_drv: got %b expected %b", col_drv, 4'b0000); end
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0 || overflow !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_flags: got valid=%b held=%b ovf=%b expected 0 0 0", key_valid, key_held, overflow);
        end
        checks++;
        if (key_code !== 4'd0) begin failures++; $display("[TB] FAIL reset_key_code: got %0d expected 0", key_code); end
        goto_cycle(1);
        checks++;
        if (col_drv !== 4'b0001) begin failures++; $display("[TB] FAIL scan_start_col: got %b expected %b", col_drv, 4'b0001); end
    endtask

    task automatic test_clean_press();
        en = 1'b1; key_ready = 1'b0; keys = 16'd1 << 6; keys2 = '0;
        do_reset();
        goto_cycle(8);
        checks++;
        if (col_drv !== 4'b0010) begin failures++; $display("[TB] FAIL clean_col1: got %b expected %b", col_drv, 4'b0010); end
        goto_cycle(9);
        checks++;
        if (col_drv !== 4'b0100) begin failures++; $display("[TB] FAIL clean_col2: got %b expected %b", col_drv, 4'b0100); end
        goto_cycle(20);
        checks++;
        if (key_valid !== 1'b0 || col_drv !== 4'b0100) begin
            failures++; $display("[TB] FAIL clean_early: got valid=%b col=%b expected 0 0100", key_valid, col_drv);
        end
        goto_cycle(21);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd6 || key_held !== 1'b1) begin
            failures++; $display("[TB] FAIL clean_emit: got valid=%b code=%0d held=%b expected 1 6 1", key_valid, key_code, key_held);
        end
        checks++;
        if (col_drv !== 4'b0100 || overflow !== 1'b0) begin
            failures++; $display("[TB] FAIL clean_hold_col: got col=%b ovf=%b expected 0100 0", col_drv, overflow);
        end
    endtask

    // Continues from test_clean_press at cycle 21.
    task automatic test_release_next();
        key_ready = 1'b1;
        goto_cycle(22);
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL ack_clear: got %b expected 0", key_valid); end
        key_ready = 1'b0;
        keys = '0;
        goto_cycle(31);
        checks++;
        if (key_held !== 1'b1 || col_drv !== 4'b0100) begin
            failures++; $display("[TB] FAIL release_early: got held=%b col=%b expected 1 0100", key_held, col_drv);
        end
        goto_cycle(33);
        checks++;
        if (key_held !== 1'b0 || col_drv !== 4'b1000) begin
            failures++; $display("[TB] FAIL release_done: got held=%b col=%b expected 0 1000", key_held, col_drv);
        end
        keys = 16'd1 << 13;
        goto_cycle(52);
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL next_early: got %b expected 0", key_valid); end
        goto_cycle(53);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd13) begin
            failures++; $display("[TB] FAIL next_emit: got valid=%b code=%0d expected 1 13", key_valid, key_code);
        end
    endtask

    task automatic test_bounce();
        en = 1'b1; key_ready = 1'b0; keys = 16'd1 << 6;
        do_reset();
        goto_cycle(13);
        keys = '0;
        goto_cycle(17);
        checks++;
        if (col_drv !== 4'b1000) begin failures++; $display("[TB] FAIL bounce_restart: got %b expected %b", col_drv, 4'b1000); end
        keys = 16'd1 << 6;
        goto_cycle(40);
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL bounce_early: got %b expected 0", key_valid); end
        goto_cycle(41);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd6) begin
            failures++; $display("[TB] FAIL bounce_emit: got valid=%b code=%0d expected 1 6", key_valid, key_code);
        end
    endtask

    task automatic test_overflow();
        en = 1'b1; key_ready = 1'b0; keys = 16'd1 << 6;
        do_reset();
        goto_cycle(22);
        keys = '0;
        goto_cycle(33);
        keys = 16'd1;
        goto_cycle(48);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_early: got %b expected 0", overflow); end
        goto_cycle(49);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_pulse: got %b expected 1", overflow); end
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd6 || key_held !== 1'b1) begin
            failures++; $display("[TB] FAIL ovf_keep: got valid=%b code=%0d held=%b expected 1 6 1", key_valid, key_code, key_held);
        end
        goto_cycle(50);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_width: got %b expected 0", overflow); end
    endtask

    task automatic test_non_pow2();
        en = 1'b1; key_ready2 = 1'b0; keys = '0; keys2 = '0;
        do_reset();
        goto_cycle(1);
        checks++;
        if (col_drv2 !== 3'b001) begin failures++; $display("[TB] FAIL np2_col0: got %b expected %b", col_drv2, 3'b001); end
        goto_cycle(5);
        checks++;
        if (col_drv2 !== 3'b010) begin failures++; $display("[TB] FAIL np2_col1: got %b expected %b", col_drv2, 3'b010); end
        goto_cycle(9);
        checks++;
        if (col_drv2 !== 3'b100) begin failures++; $display("[TB] FAIL np2_col2: got %b expected %b", col_drv2, 3'b100); end
        goto_cycle(13);
        checks++;
        if (col_drv2 !== 3'b001) begin failures++; $display("[TB] FAIL np2_wrap: got %b expected %b", col_drv2, 3'b001); end
        keys2 = 15'd1 << 14;
        goto_cycle(24);
        checks++;
        if (key_valid2 !== 1'b0) begin failures++; $display("[TB] FAIL np2_early: got %b expected 0", key_valid2); end
        goto_cycle(25);
        checks++;
        if (key_valid2 !== 1'b1 || key_code2 !== 4'd14 || key_held2 !== 1'b1) begin
            failures++; $display("[TB] FAIL np2_emit: got valid=%b code=%0d held=%b expected 1 14 1", key_valid2, key_code2, key_held2);
        end
        keys2 = '0;
    endtask

    task automatic test_en_drop_reset();
        en = 1'b1; key_ready = 1'b0; keys = 16'd1 << 6;
        do_reset();
        goto_cycle(22);
        keys = '0;
        goto_cycle(33);
        keys = 16'd1;
        goto_cycle(42);
        en = 1'b0;
        goto_cycle(43);
        checks++;
        if (col_drv !== 4'b0000 || key_held !== 1'b0) begin
            failures++; $display("[TB] FAIL endrop_idle: got col=%b held=%b expected 0000 0", col_drv, key_held);
        end
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd6) begin
            failures++; $display("[TB] FAIL endrop_keep: got valid=%b code=%0d expected 1 6", key_valid, key_code);
        end
        goto_cycle(46);
        key_ready = 1'b1;
        goto_cycle(47);
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL endrop_ack: got %b expected 0", key_valid); end
        key_ready = 1'b0;
        en = 1'b1;
        goto_cycle(48);
        checks++;
        if (col_drv !== 4'b0001) begin failures++; $display("[TB] FAIL reenable_col: got %b expected %b", col_drv, 4'b0001); end
        goto_cycle(60);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd0 || key_held !== 1'b1) begin
            failures++; $display("[TB] FAIL reenable_emit: got valid=%b code=%0d held=%b expected 1 0 1", key_valid, key_code, key_held);
        end
        keys = 16'd1 << 6;
        goto_cycle(61);
        key_ready = 1'b1;
        goto_cycle(62);
        key_ready = 1'b0;
        goto_cycle(62);
        RESET = 1'b1;
        goto_cycle(63);
        checks++;
        if (col_drv !== 4'b0000 || key_valid !== 1'b0 || key_held !== 1'b0 || overflow !== 1'b0) begin
            failures++; $display("[TB] FAIL midreset_flags: got col=%b valid=%b held=%b ovf=%b expected 0000 0 0 0", col_drv, key_valid, key_held, overflow);
        end
        RESET = 1'b0;
        keys = '0;
    endtask

    // Variant of the held-reset check with a non-zero pending code.
    task automatic test_reset_drops_key();
        en = 1'b1; key_ready = 1'b0; keys = 16'd1 << 6;
        do_reset();
        goto_cycle(25);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd6) begin
            failures++; $display("[TB] FAIL pre_reset_key: got valid=%b code=%0d expected 1 6", key_valid, key_code);
        end
        RESET = 1'b1;
        goto_cycle(26);
        checks++;
        if (key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_drop_key: got code=%0d valid=%b held=%b expected 0 0 0", key_code, key_valid, key_held);
        end
        RESET = 1'b0;
        keys = '0;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        RESET = 1'b1; en = 1'b0; key_ready = 1'b0; key_ready2 = 1'b0;
        keys = '0; keys2 = '0;
        test_reset();
        test_clean_press();
        test_release_next();
        test_bounce();
        test_overflow();
        test_non_pow2();
        test_en_drop_reset();
        test_reset_drops_key();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
